// File: rtl/serving_wb2ram_pkg.sv
// Shared definitions for the Wishbone-to-byte-RAM bridge: FSM encoding, lane count
// and byte-lane helpers.
package serving_wb2ram_pkg;

  localparam int LANES = 4;
  localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    ACK     = 3'd4
  } state_e;

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/serving_wb2ram.sv
// Converts one 32-bit Wishbone classic access into four sequential little-endian
// byte accesses on the serving_ram write/read port. One transaction in flight.
module serving_wb2ram
  import serving_wb2ram_pkg::*;
#(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [aw-1:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic [aw-1:0] o_waddr,
  output logic [7:0]    o_wdata,
  output logic          o_wen,
  output logic [aw-1:0] o_raddr,
  output logic          o_ren,
  input  logic [7:0]    i_rdata,
  input  logic          i_ack
);

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [aw-3:0] adr_q, adr_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   rdt_q, rdt_d;
  logic          ack_dly_q, ack_dly_d;

  // Word aligned: the low address bits carry no information.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^i_wb_adr[1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    rdt_d     = rdt_q;
    ack_dly_d = (state_q == ACK);

    case (state_q)
      IDLE: begin
        // The master still holds cyc in the cycle after ack; don't restart on it.
        if (i_wb_cyc && !ack_dly_q) begin
          adr_d   = i_wb_adr[aw-1:2];
          sel_d   = i_wb_sel;
          dat_d   = i_wb_dat;
          cnt_d   = 2'd0;
          state_d = i_wb_we ? WRITE : RD_REQ;
        end
      end
      WRITE: begin
        if (!i_wb_cyc)               state_d = IDLE;
        else if (cnt_q == LAST_LANE) state_d = ACK;
        else                         cnt_d   = cnt_q + 2'd1;
      end
      RD_REQ: begin
        state_d = i_wb_cyc ? RD_WAIT : IDLE;
      end
      RD_WAIT: begin
        if (!i_wb_cyc) begin
          state_d = IDLE;
        end else if (i_ack) begin
          rdt_d = put_byte(rdt_q, cnt_q, i_rdata);
          if (cnt_q == LAST_LANE) begin
            state_d = ACK;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            state_d = RD_REQ;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      adr_q     <= '0;
      sel_q     <= 4'd0;
      dat_q     <= 32'd0;
      rdt_q     <= 32'd0;
      ack_dly_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      rdt_q     <= rdt_d;
      ack_dly_q <= ack_dly_d;
    end
  end

  // Outputs decode directly from registered state, so reset clears them at once.
  assign o_waddr  = {adr_q, cnt_q};
  assign o_raddr  = {adr_q, cnt_q};
  assign o_wdata  = get_byte(dat_q, cnt_q);
  assign o_wen    = (state_q == WRITE) && sel_q[cnt_q];
  assign o_ren    = (state_q == RD_REQ);
  assign o_wb_ack = (state_q == ACK);
  assign o_wb_rdt = rdt_q;

endmodule
